gf_mult_serial: RTL and testbench

Parametrised, sequential digit-serial multiplier over GF(2^M) using a fixed irreducible reduction polynomial. It is the pipelined-interface successor to the team's flat combinational GF multipliers, and trades area for latency by processing DIGIT bits of operand B per cycle. It sits between operand producers and consumers in the datapath, with valid/ready handshakes on both sides.

---
 rtl/gf_pkg.sv | 55 +++++
 rtl/gf_digit_step.sv | 20 ++
 rtl/gf_mult_serial.sv | 123 ++++++++++++
 tb/tb_gf_mult_serial.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^M) definitions: default field, FSM state type and digit-serial helpers.
// Helpers work on GF_W-bit vectors; callers pass the live field degree m (m <= GF_W).
package gf_pkg;

  localparam int GF_W = 32;
  localparam int GF_M_DEFAULT = 9;
  localparam logic [GF_W-1:0] GF_POLY_DEFAULT = 32'h0000_0011;
  localparam logic [GF_W-1:0] GF_ONE = 32'h0000_0001;

  typedef enum logic [1:0] {IDLE, RUN, DONE} gf_state_e;

  function automatic logic [GF_W-1:0] gf_mask(input int m);
    logic [GF_W-1:0] r;
    r = '0;
    for (int i = 0; i < GF_W; i++) begin
      r[i] = (i < m);
    end
    return r;
  endfunction

  // Multiply by x^digit, folding x^m back in through poly after every single shift.
  function automatic logic [GF_W-1:0] gf_xtime_d(input logic [GF_W-1:0] acc,
                                                 input int digit,
                                                 input logic [GF_W-1:0] poly,
                                                 input int m);
    logic [GF_W-1:0] r;
    logic msb;
    r = acc;
    for (int i = 0; i < GF_W; i++) begin
      if (i < digit) begin
        msb = |(r & (GF_ONE << (m - 1)));
        r = (r << 1) & gf_mask(m);
        if (msb) r = r ^ (poly & gf_mask(m));
      end
    end
    return r;
  endfunction

  function automatic logic [GF_W-1:0] gf_mul_digit(input logic [GF_W-1:0] a,
                                                   input logic [GF_W-1:0] d,
                                                   input int digit,
                                                   input logic [GF_W-1:0] poly,
                                                   input int m);
    logic [GF_W-1:0] r;
    r = '0;
    for (int j = GF_W - 1; j >= 0; j--) begin
      if (j < digit) begin
        r = gf_xtime_d(r, 1, poly, m);
        if (|((d >> j) & GF_ONE)) r = r ^ a;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_digit_step.sv
// One digit-serial iteration: acc_next = acc * x^DIGIT mod P  XOR  a * d mod P.
module gf_digit_step
  import gf_pkg::*;
#(
  parameter int M = GF_M_DEFAULT,
  parameter logic [M-1:0] POLY = GF_POLY_DEFAULT[M-1:0],
  parameter int DIGIT = 1
) (
  input  logic [M-1:0]     acc,
  input  logic [M-1:0]     a,
  input  logic [DIGIT-1:0] d,
  output logic [M-1:0]     acc_next
);

  always_comb begin
    acc_next = M'(gf_xtime_d(GF_W'(acc), DIGIT, GF_W'(POLY), M) ^
                  gf_mul_digit(GF_W'(a), GF_W'(d), DIGIT, GF_W'(POLY), M));
  end

endmodule

// File: rtl/gf_mult_serial.sv
// Digit-serial GF(2^M) multiplier with valid/ready handshakes on both sides.
// Define GF_MAC_EN to add operand in_c, giving out_p = A*B XOR C.
module gf_mult_serial
  import gf_pkg::*;
#(
  parameter int M = GF_M_DEFAULT,
  parameter logic [M-1:0] POLY = GF_POLY_DEFAULT[M-1:0],
  parameter int DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_a,
  input  logic [M-1:0] in_b,
`ifdef GF_MAC_EN
  input  logic [M-1:0] in_c,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_p,
  output logic         busy
);

  localparam int NCYC = (M + DIGIT - 1) / DIGIT;
  localparam int BW = NCYC * DIGIT;
  localparam int CW = (NCYC > 1) ? $clog2(NCYC) : 1;

  gf_state_e state_q, state_d;
  logic [M-1:0]  a_q, a_d;
  logic [BW-1:0] b_q, b_d;
  logic [M-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  out_p_q, out_p_d;
  logic [M-1:0]  acc_next;
  logic [M-1:0]  acc_init;
  logic [DIGIT-1:0] digit;

`ifdef GF_MAC_EN
  assign acc_init = in_c;
`else
  assign acc_init = '0;
`endif

  // B is shifted left each step, so the top slice is always the next digit (MSB-first).
  assign digit = b_q[BW-1 -: DIGIT];

  gf_digit_step #(
    .M(M),
    .POLY(POLY),
    .DIGIT(DIGIT)
  ) u_step (
    .acc(acc_q),
    .a(a_q),
    .d(digit),
    .acc_next(acc_next)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_p_d   = out_p_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      RUN: begin
        busy  = 1'b1;
        acc_d = acc_next;
        b_d   = b_q << DIGIT;
        if (cnt_q == '0) begin
          out_p_d = acc_next;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accept overrides the DONE->IDLE exit, giving back-to-back retire and capture.
    if (in_valid && in_ready) begin
      a_d     = in_a;
      b_d     = BW'(in_b);
      acc_d   = acc_init;
      cnt_d   = CW'(NCYC - 1);
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_p_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_p_q <= out_p_d;
    end
  end

  assign out_p = out_p_q;

endmodule

// File: tb/tb_gf_mult_serial.sv
// Self-checking bench for gf_mult_serial: directed table, stall/back-to-back/reset sequences
// and a random sweep over DIGIT in {1,2,4,9} against a plain polynomial-arithmetic model.
module tb_gf_mult_serial;

  localparam int M = 9;
  localparam int NCYC_MAIN = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sweep_rst_n = 1'b0;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [8:0] in_a, in_b, in_c, out_p;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] sweep_done = 4'h0;

  gf_mult_serial #(.M(9), .POLY(9'h011), .DIGIT(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
`ifdef GF_MAC_EN
    .in_c(in_c),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p(out_p),
    .busy(busy)
  );

  // Reference: full carry-less product, then long division by x^9+x^4+1.
  function automatic logic [8:0] gf_ref(input logic [8:0] a, input logic [8:0] b,
                                        input logic [8:0] c);
    logic [16:0] p;
    p = '0;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 9; j++)
        if (a[i] && b[j]) p[i+j] = ~p[i+j];
    for (int k = 16; k >= 9; k--)
      if (p[k]) p = p ^ (17'h00211 << (k - 9));
    return p[8:0] ^ c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
    int tries;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_c = c;
    tries = 0;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) checkOutput("accept timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 9'($urandom);
    in_b = 9'($urandom);
    in_c = 9'($urandom);
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [8:0] a;
    logic [8:0] b;
    logic [8:0] c;
    logic [8:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int lat;

    vecs.push_back('{9'h001, 9'h001, 9'h000, 9'h001});
    vecs.push_back('{9'h100, 9'h002, 9'h000, 9'h011});
    vecs.push_back('{9'h100, 9'h100, 9'h000, 9'h0C4});
    vecs.push_back('{9'h1FF, 9'h000, 9'h000, 9'h000});
    vecs.push_back('{9'h000, 9'h1AB, 9'h000, 9'h000});
    vecs.push_back('{9'h0AB, 9'h1C3, 9'h000, gf_ref(9'h0AB, 9'h1C3, 9'h000)});
`ifdef GF_MAC_EN
    vecs.push_back('{9'h100, 9'h002, 9'h011, 9'h000});
    vecs.push_back('{9'h000, 9'h000, 9'h155, 9'h155});
`endif

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;
    in_c = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_p", 32'(out_p), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    sweep_rst_n = 1'b1;
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c);
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'd1);
      checkOutput($sformatf("vec%0d in_ready in run", i), 32'(in_ready), 32'd0);
      waitResult(lat);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(NCYC_MAIN));
      checkOutput($sformatf("vec%0d out_p", i), 32'(out_p), 32'(vecs[i].exp));
      retire();
      checkOutput($sformatf("vec%0d retired", i), 32'(out_valid), 32'd0);
      checkOutput($sformatf("vec%0d out_p hold", i), 32'(out_p), 32'(vecs[i].exp));
    end

    // Stall for five cycles, then retire and accept on the same edge.
    applyStimulus(9'h100, 9'h002, 9'h000);
    waitResult(lat);
    checkOutput("stall first latency", 32'(lat), 32'(NCYC_MAIN));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall out_p", 32'(out_p), 32'h011);
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 9'h100;
    in_b = 9'h100;
    in_c = 9'h000;
    #1;
    checkOutput("b2b in_ready comb", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_a = 9'h1FF;
    in_b = 9'h1FF;
    checkOutput("b2b out_valid drop", 32'(out_valid), 32'd0);
    checkOutput("b2b busy", 32'(busy), 32'd1);
    waitResult(lat);
    checkOutput("b2b latency", 32'(lat), 32'(NCYC_MAIN));
    checkOutput("b2b out_p", 32'(out_p), 32'h0C4);
    retire();

    // Abort mid-RUN with reset: nothing should surface, then a fresh op completes.
    applyStimulus(9'h1FF, 9'h1AB, 9'h000);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort out_p", 32'(out_p), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    applyStimulus(9'h100, 9'h002, 9'h000);
    waitResult(lat);
    checkOutput("post-abort latency", 32'(lat), 32'(NCYC_MAIN));
    checkOutput("post-abort out_p", 32'(out_p), 32'h011);
    retire();

    for (int i = 0; i < 80000 && sweep_done != 4'hF; i++) @(posedge clk);
    checkOutput("sweep completion", 32'(sweep_done), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  for (genvar g = 0; g < 4; g++) begin : sweep
    localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 9;
    localparam int NC = (M + D - 1) / D;

    logic       iv, ir, ov, orr, bz;
    logic [8:0] ia, ib, ic, op;

    gf_mult_serial #(.M(9), .POLY(9'h011), .DIGIT(D)) u_dut (
      .clk(clk),
      .rst_n(sweep_rst_n),
      .in_valid(iv),
      .in_ready(ir),
      .in_a(ia),
      .in_b(ib),
`ifdef GF_MAC_EN
      .in_c(ic),
`endif
      .out_valid(ov),
      .out_ready(orr),
      .out_p(op),
      .busy(bz)
    );

    initial begin
      logic [8:0] a, b, c, expv;
      int lat;
      iv = 1'b0;
      orr = 1'b0;
      ia = '0;
      ib = '0;
      ic = '0;
      wait (sweep_rst_n === 1'b1);
      for (int n = 0; n < 1000; n++) begin
        a = 9'($urandom);
        b = 9'($urandom);
`ifdef GF_MAC_EN
        c = 9'($urandom);
`else
        c = 9'h000;
`endif
        if ($urandom_range(0, 15) == 0) a = 9'h000;
        if ($urandom_range(0, 15) == 1) b = 9'h000;
        expv = gf_ref(a, b, c);
        @(negedge clk);
        iv = 1'b1;
        ia = a;
        ib = b;
        ic = c;
        if (!ir) checkOutput($sformatf("sweep D=%0d in_ready", D), 32'(ir), 32'd1);
        @(posedge clk);
        #1;
        iv = 1'b0;
        ia = 9'($urandom);
        ib = 9'($urandom);
        lat = 0;
        while (!ov && lat < 30) begin
          @(posedge clk);
          #1;
          lat++;
        end
        checkOutput($sformatf("sweep D=%0d latency", D), 32'(lat), 32'(NC));
        checkOutput($sformatf("sweep D=%0d a=%0h b=%0h c=%0h", D, a, b, c), 32'(op), 32'(expv));
        @(negedge clk);
        orr = 1'b1;
        @(posedge clk);
        #1;
        orr = 1'b0;
        if (ov) checkOutput($sformatf("sweep D=%0d retire", D), 32'(ov), 32'd0);
      end
      sweep_done[g] = 1'b1;
    end
  end

endmodule
